// File: rtl/ifns_pkg.sv
// ---------------------------------------------------------------------------
// ifns_pkg
// Shared constants and helpers for the 14-wire IFNS crosstalk-avoidance code.
//   IFNS_CODE_W / IFNS_DATA_W : codeword and data widths
//   IFNS_MAX_DATA             : largest value that fits the decoded data
//   IFNS_W[1:14]              : Fibonacci weight of wire dk
//   ifns_ft_violation()       : forbidden-transition check between two codewords
// ---------------------------------------------------------------------------
package ifns_pkg;

  localparam int IFNS_CODE_W   = 14;
  localparam int IFNS_DATA_W   = 10;
  localparam int IFNS_MAX_DATA = 1023;

  localparam int IFNS_W [1:14] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610};

  // Two neighbouring wires that both toggle and end up at different levels
  // must have moved in opposite directions, which is the crosstalk worst case.
  function automatic logic ifns_ft_violation(input logic [IFNS_CODE_W-1:0] prev,
                                             input logic [IFNS_CODE_W-1:0] cur);
    logic violation;
    violation = 1'b0;
    for (int k = 0; k < IFNS_CODE_W - 1; k++) begin
      if ((prev[k] ^ cur[k]) && (prev[k+1] ^ cur[k+1]) && (cur[k] != cur[k+1])) begin
        violation = 1'b1;
      end
    end
    return violation;
  endfunction

endpackage

// File: rtl/ifns_weight_sum.sv
// ---------------------------------------------------------------------------
// ifns_weight_sum
// Combinational Fibonacci-weighted adder for a group of 7 code wires.
//   OFFSET   : index of the wire just below this group (0 -> wires 1..7,
//              7 -> wires 8..14)
//   OUT_W    : width of the partial sum
//   i_wires  : the 7 wires of the group, i_wires[0] is the lowest wire
//   o_sum    : sum of the weights of the wires that are set
// ---------------------------------------------------------------------------
module ifns_weight_sum
  import ifns_pkg::*;
#(
  parameter int OFFSET = 0,
  parameter int OUT_W  = 11
) (
  input  logic [6:0]       i_wires,
  output logic [OUT_W-1:0] o_sum
);

  // Accumulate the weight of every set wire; OUT_W is sized by the caller
  // to hold the group maximum, so no carry is lost.
  always_comb begin
    o_sum = '0;
    for (int k = 0; k < 7; k++) begin
      if (i_wires[k]) begin
        o_sum = o_sum + OUT_W'(IFNS_W[OFFSET + k + 1]);
      end
    end
  end

endmodule

// File: rtl/ifns_decoder_14.sv
// ---------------------------------------------------------------------------
// ifns_decoder_14
// Receive-side decoder of the 14-wire IFNS code: two-stage pipeline that
// turns each codeword into 10-bit data and flags forbidden transitions.
//   clock     : clock, all logic on posedge
//   rst       : synchronous active-high reset
//   codein    : codeword, codein[k-1] is wire dk
//   in_valid  : codein valid
//   in_ready  : decoder accepts codein this cycle
//   dataout   : decoded data (sum mod 1024)
//   out_valid : dataout and flags valid
//   out_ready : downstream accepts this cycle
//   range_err : weighted sum exceeded 1023
//   ft_err    : forbidden transition versus previous accepted codeword
// ---------------------------------------------------------------------------
module ifns_decoder_14
  import ifns_pkg::*;
(
  input  logic                   clock,
  input  logic                   rst,
  input  logic [IFNS_CODE_W-1:0] codein,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [IFNS_DATA_W-1:0] dataout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   range_err,
  output logic                   ft_err
);

  logic [5:0]             w_lo;
  logic [10:0]            w_hi;
  logic [10:0]            w_sum;
  logic                   w_s2Load;
  logic                   w_s1Load;
  logic                   w_accept;
  logic                   w_ft;

  logic                   r_v1;
  logic [5:0]             r_lo;
  logic [10:0]            r_hi;
  logic                   r_ft1;
  logic                   r_v2;
  logic [IFNS_DATA_W-1:0] r_dataout;
  logic                   r_range;
  logic                   r_ft2;
  logic [IFNS_CODE_W-1:0] r_prev;

  ifns_weight_sum #(.OFFSET(0), .OUT_W(6)) u_lo (
    .i_wires (codein[6:0]),
    .o_sum   (w_lo)
  );

  ifns_weight_sum #(.OFFSET(7), .OUT_W(11)) u_hi (
    .i_wires (codein[13:7]),
    .o_sum   (w_hi)
  );

  // Back-pressure ripples combinationally from out_ready to in_ready; there
  // is no skid buffer, so a stage only loads when the one after it moves.
  assign w_s2Load = ~r_v2 | out_ready;
  assign w_s1Load = ~r_v1 | w_s2Load;
  assign in_ready = w_s1Load;
  assign w_accept = in_valid & in_ready;
  assign w_ft     = ifns_ft_violation(r_prev, codein);
  assign w_sum    = 11'(r_lo) + r_hi;

  // Stage 1: partial sums split into two 7-wire groups to shorten the adder.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_lo   <= '0;
      r_hi   <= '0;
      r_ft1  <= 1'b0;
      r_prev <= '0;
    end else begin
      if (w_s1Load) begin
        r_v1 <= w_accept;
      end
      if (w_accept) begin
        r_lo   <= w_lo;
        r_hi   <= w_hi;
        r_ft1  <= w_ft;
        r_prev <= codein;
      end
    end
  end

  // Stage 2: final sum; payload only changes when a real word arrives so the
  // outputs stay frozen during a stall.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_v2      <= 1'b0;
      r_dataout <= '0;
      r_range   <= 1'b0;
      r_ft2     <= 1'b0;
    end else if (w_s2Load) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_dataout <= w_sum[IFNS_DATA_W-1:0];
        r_range   <= (w_sum > 11'(IFNS_MAX_DATA));
        r_ft2     <= r_ft1;
      end
    end
  end

  // No output beat is presented while reset is being applied.
  assign out_valid = r_v2 & ~rst;
  assign dataout   = r_dataout;
  assign range_err = r_range;
  assign ft_err    = r_ft2;

endmodule
